// File: rtl/mips_alu_pkg.sv
// mips_alu_pkg: ALU control codes, MIPS opcode/funct constants and the decoded issue control bundle
package mips_alu_pkg;
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    typedef struct packed {
        logic [3:0] alu_ctrl;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch_eq;
        logic       branch_ne;
        logic       ovf_trap_en;
        logic       illegal;
    } issue_t;
endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational opcode/funct/imm16 decode into ALU control, operand 2 and destination
//   in:  opcode, funct, rt_data, imm16, rt_addr, rd_addr
//   out: ctl (issue_t control bundle), op2 (rt_data or extended imm16), dest (write-back register)
module alu_ctrl_decode
    import mips_alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [15:0]       imm16,
    input  logic [REG_W-1:0]  rt_addr,
    input  logic [REG_W-1:0]  rd_addr,
    output issue_t            ctl,
    output logic [DATA_W-1:0] op2,
    output logic [REG_W-1:0]  dest
);
    logic [DATA_W-1:0] sext, zext;
    assign sext = {{(DATA_W-16){imm16[15]}}, imm16};
    assign zext = {{(DATA_W-16){1'b0}}, imm16};
    always_comb begin
        ctl = '0;
        ctl.alu_ctrl = ALU_ADD;
        op2 = rt_data;
        dest = '0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU: ctl.ovf_trap_en = funct == FN_ADD;
                    FN_SUB, FN_SUBU: begin
                        ctl.alu_ctrl = ALU_SUB;
                        ctl.ovf_trap_en = funct == FN_SUB;
                    end
                    FN_AND: ctl.alu_ctrl = ALU_AND;
                    FN_OR: ctl.alu_ctrl = ALU_OR;
                    default: ctl.illegal = 1'b1;
                endcase
                ctl.reg_write = !ctl.illegal;
                dest = ctl.illegal ? '0 : rd_addr;
            end
            OP_ADDI, OP_ADDIU: begin
                op2 = sext;
                dest = rt_addr;
                ctl.reg_write = 1'b1;
                ctl.ovf_trap_en = opcode == OP_ADDI;
            end
            OP_ANDI, OP_ORI: begin
                ctl.alu_ctrl = opcode == OP_ANDI ? ALU_AND : ALU_OR;
                op2 = zext;
                dest = rt_addr;
                ctl.reg_write = 1'b1;
            end
            OP_LW: begin
                op2 = sext;
                dest = rt_addr;
                ctl.reg_write = 1'b1;
                ctl.mem_read = 1'b1;
            end
            OP_SW: begin
                op2 = sext;
                ctl.mem_write = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctl.alu_ctrl = ALU_SUB;
                ctl.branch_eq = opcode == OP_BEQ;
                ctl.branch_ne = opcode == OP_BNE;
            end
            default: ctl.illegal = 1'b1;
        endcase
        // $zero is never a real write-back target
        ctl.reg_write = ctl.reg_write & (|dest);
    end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID->EX issue stage, decodes ALU control/operands into a 2-entry skid-buffered bundle
//   in:  clk, reset (async, high), flush, in_valid, opcode, funct, rs_data, rt_data, imm16, rt_addr,
//        rd_addr, out_ready
//   out: in_ready (registered), out_valid, alu_ctrl, operand1, operand2, dest_reg, reg_write, mem_read,
//        mem_write, branch_eq, branch_ne, ovf_trap_en, illegal
module alu_issue_stage
    import mips_alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [15:0]       imm16,
    input  logic [REG_W-1:0]  rt_addr,
    input  logic [REG_W-1:0]  rd_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        alu_ctrl,
    output logic [DATA_W-1:0] operand1,
    output logic [DATA_W-1:0] operand2,
    output logic [REG_W-1:0]  dest_reg,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              branch_eq,
    output logic              branch_ne,
    output logic              ovf_trap_en,
    output logic              illegal
);
    typedef struct packed {
        issue_t              ctl;
        logic [DATA_W-1:0]   op1;
        logic [DATA_W-1:0]   op2;
        logic [REG_W-1:0]    dest;
    } bundle_t;
    issue_t            dec_ctl;
    logic [DATA_W-1:0] dec_op2;
    logic [REG_W-1:0]  dec_dest;
    bundle_t           in_b, out_q, skid_q;
    logic              skid_valid, accept, fire;
    alu_ctrl_decode #(.DATA_W(DATA_W), .REG_W(REG_W)) u_dec (
        .opcode  (opcode),
        .funct   (funct),
        .rt_data (rt_data),
        .imm16   (imm16),
        .rt_addr (rt_addr),
        .rd_addr (rd_addr),
        .ctl     (dec_ctl),
        .op2     (dec_op2),
        .dest    (dec_dest)
    );
    assign in_b   = {dec_ctl, rs_data, dec_op2, dec_dest};
    assign accept = in_valid & in_ready;
    assign fire   = out_valid & out_ready;
    // in_ready only drops when the skid captures, so accept and a full skid never coincide
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
            out_q      <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else if (!out_valid || fire) begin
            if (skid_valid || accept) out_q <= skid_valid ? skid_q : in_b;
            out_valid  <= skid_valid | accept;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else if (accept) begin
            skid_q     <= in_b;
            skid_valid <= 1'b1;
            in_ready   <= 1'b0;
        end
    end
    assign alu_ctrl    = out_q.ctl.alu_ctrl;
    assign operand1    = out_q.op1;
    assign operand2    = out_q.op2;
    assign dest_reg    = out_q.dest;
    assign reg_write   = out_q.ctl.reg_write;
    assign mem_read    = out_q.ctl.mem_read;
    assign mem_write   = out_q.ctl.mem_write;
    assign branch_eq   = out_q.ctl.branch_eq;
    assign branch_ne   = out_q.ctl.branch_ne;
    assign ovf_trap_en = out_q.ctl.ovf_trap_en;
    assign illegal     = out_q.ctl.illegal;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: scoreboard bench for the ALU issue stage
module tb_alu_issue_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  opcode = '0;
    logic [5:0]  funct = '0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic [15:0] imm16 = '0;
    logic [4:0]  rt_addr = '0;
    logic [4:0]  rd_addr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  alu_ctrl;
    logic [31:0] operand1, operand2;
    logic [4:0]  dest_reg;
    logic        reg_write, mem_read, mem_write, branch_eq, branch_ne, ovf_trap_en, illegal;
    logic [79:0] obs;
    logic [79:0] sb [$];
    int          n_chk = 0;
    int          n_pass = 0;
    logic [11:0] tbl [0:17] = '{
        12'h020, 12'h021, 12'h022, 12'h023, 12'h024, 12'h025, {6'h08, 6'h00}, {6'h09, 6'h11},
        {6'h0C, 6'h00}, {6'h0D, 6'h3F}, {6'h23, 6'h05}, {6'h2B, 6'h00}, {6'h04, 6'h00},
        {6'h05, 6'h20}, {6'h3F, 6'h00}, 12'h000, 12'h02A, {6'h02, 6'h00}
    };

    alu_issue_stage #(.DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct(funct), .rs_data(rs_data), .rt_data(rt_data), .imm16(imm16),
        .rt_addr(rt_addr), .rd_addr(rd_addr), .out_valid(out_valid), .out_ready(out_ready),
        .alu_ctrl(alu_ctrl), .operand1(operand1), .operand2(operand2), .dest_reg(dest_reg),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .branch_eq(branch_eq),
        .branch_ne(branch_ne), .ovf_trap_en(ovf_trap_en), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign obs = {alu_ctrl, operand1, operand2, dest_reg, reg_write, mem_read, mem_write,
                  branch_eq, branch_ne, ovf_trap_en, illegal};

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [79:0] model(input logic [5:0] op, input logic [5:0] fn,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [15:0] imm, input logic [4:0] rt,
                                          input logic [4:0] rd);
        logic [3:0]  alu;
        logic [31:0] o2, se;
        logic [4:0]  d;
        logic        rw, mr, mw, be, bn, tr, il;
        alu = 4'd0; o2 = b; d = 5'd0;
        rw = 0; mr = 0; mw = 0; be = 0; bn = 0; tr = 0; il = 0;
        se = {{16{imm[15]}}, imm};
        if (op == 6'h00 && fn >= 6'h20 && fn <= 6'h25) begin
            d = rd; rw = 1;
            alu = fn < 6'h22 ? 4'd0 : fn < 6'h24 ? 4'd1 : fn == 6'h24 ? 4'd2 : 4'd3;
            tr = fn == 6'h20 || fn == 6'h22;
        end else if (op == 6'h08 || op == 6'h09) begin
            o2 = se; d = rt; rw = 1; tr = op == 6'h08;
        end else if (op == 6'h0C || op == 6'h0D) begin
            alu = op == 6'h0C ? 4'd2 : 4'd3; o2 = {16'h0, imm}; d = rt; rw = 1;
        end else if (op == 6'h23) begin
            o2 = se; d = rt; rw = 1; mr = 1;
        end else if (op == 6'h2B) begin
            o2 = se; mw = 1;
        end else if (op == 6'h04 || op == 6'h05) begin
            alu = 4'd1; be = op == 6'h04; bn = op == 6'h05;
        end else il = 1;
        if (d == 5'd0) rw = 0;
        return {alu, a, o2, d, rw, mr, mw, be, bn, tr, il};
    endfunction

    // Scoreboard: push on accept, pop and compare on fire; flush and reset discard everything in flight.
    always @(negedge clk) begin
        if (reset || flush) sb.delete();
        else begin
            if (out_valid && out_ready) begin
                if (sb.size() != 0) chk("bundle", obs, sb.pop_front());
                else chk("spurious_out_valid", out_valid, 1'b0);
            end
            if (in_valid && in_ready)
                sb.push_back(model(opcode, funct, rs_data, rt_data, imm16, rt_addr, rd_addr));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [15:0] imm, input logic [4:0] rt,
                         input logic [4:0] rd);
        opcode = op; funct = fn; rs_data = a; rt_data = b; imm16 = imm;
        rt_addr = rt; rd_addr = rd; in_valid = 1'b1;
    endtask

    task automatic issue1(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a,
                          input logic [31:0] b, input logic [15:0] imm, input logic [4:0] rt,
                          input logic [4:0] rd);
        drive(op, fn, a, b, imm, rt, rd);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        #1 reset = 1'b1;
        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_alu_ctrl", alu_ctrl, 4'b0000);
        @(posedge clk);
        #3 reset = 1'b0;
        step();
        out_ready = 1'b1;
        issue1(6'h00, 6'h20, 32'd5, 32'd7, 16'h1820, 5'd7, 5'd3);
        chk("add_valid", out_valid, 1'b1);
        chk("add_alu", alu_ctrl, 4'b0000);
        chk("add_op1", operand1, 32'd5);
        chk("add_op2", operand2, 32'd7);
        chk("add_dest", dest_reg, 5'd3);
        chk("add_rw", reg_write, 1'b1);
        chk("add_trap", ovf_trap_en, 1'b1);
        issue1(6'h0C, 6'h00, 32'd1, 32'd2, 16'hFFFF, 5'd4, 5'd0);
        chk("andi_op2", operand2, 32'h0000FFFF);
        chk("andi_alu", alu_ctrl, 4'b0010);
        issue1(6'h08, 6'h00, 32'd1, 32'd2, 16'hFFFF, 5'd4, 5'd0);
        chk("addi_op2", operand2, 32'hFFFFFFFF);
        chk("addi_alu", alu_ctrl, 4'b0000);
        issue1(6'h04, 6'h00, 32'd9, 32'd9, 16'h0010, 5'd9, 5'd0);
        chk("beq_alu", alu_ctrl, 4'b0001);
        chk("beq_flag", branch_eq, 1'b1);
        chk("beq_rw", reg_write, 1'b0);
        issue1(6'h3F, 6'h00, 32'd1, 32'd2, 16'h0000, 5'd4, 5'd5);
        chk("ill_flag", illegal, 1'b1);
        chk("ill_enables", {reg_write, mem_read, mem_write, branch_eq, branch_ne, ovf_trap_en}, 6'b0);
        issue1(6'h00, 6'h20, 32'd1, 32'd2, 16'h0000, 5'd4, 5'd0);
        chk("rd0_rw", reg_write, 1'b0);
        // Back-to-back stream of every table entry with the consumer always ready
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i][11:6], tbl[i][5:0], $urandom, $urandom, 16'($urandom), 5'($urandom), 5'($urandom));
            step();
        end
        in_valid = 1'b0;
        step();
        chk("stream_drained", out_valid, 1'b0);
        // Back-pressure: A lands in the output register, B in the skid
        out_ready = 1'b0;
        drive(6'h00, 6'h22, 32'hA, 32'h1, 16'h0, 5'd1, 5'd10);
        step();
        drive(6'h00, 6'h25, 32'hB, 32'h2, 16'h0, 5'd2, 5'd11);
        step();
        in_valid = 1'b0;
        chk("bp_in_ready_low", in_ready, 1'b0);
        chk("bp_out_valid", out_valid, 1'b1);
        step();
        step();
        chk("bp_hold_op1", operand1, 32'hA);
        out_ready = 1'b1;
        step();
        chk("bp_in_ready_high", in_ready, 1'b1);
        chk("bp_b_next", operand1, 32'hB);
        chk("bp_b_valid", out_valid, 1'b1);
        step();
        chk("bp_empty", out_valid, 1'b0);
        // Random traffic with random stalls
        for (int i = 0; i < 300; i++) begin
            int k;
            k = int'($urandom_range(0, 17));
            drive(tbl[k][11:6], tbl[k][5:0], $urandom, $urandom, 16'($urandom), 5'($urandom), 5'($urandom));
            in_valid = $urandom_range(0, 1) == 1;
            out_ready = $urandom_range(0, 3) != 0;
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        chk("rand_sb_drained", sb.size(), 0);
        // Flush with both entries full and a new word offered
        out_ready = 1'b0;
        drive(6'h00, 6'h20, 32'h11, 32'h1, 16'h0, 5'd1, 5'd2);
        step();
        drive(6'h00, 6'h20, 32'h22, 32'h1, 16'h0, 5'd1, 5'd2);
        step();
        chk("fl_full", in_ready, 1'b0);
        drive(6'h00, 6'h20, 32'h33, 32'h1, 16'h0, 5'd1, 5'd2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", out_valid, 1'b0);
        chk("fl_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        repeat (3) step();
        chk("fl_no_emit", out_valid, 1'b0);
        // Flush on an empty stage drops the word offered in that cycle
        drive(6'h00, 6'h20, 32'h44, 32'h1, 16'h0, 5'd1, 5'd2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl2_dropped", out_valid, 1'b0);
        // Async reset in the middle of a stall
        out_ready = 1'b0;
        drive(6'h00, 6'h25, 32'h55, 32'h1, 16'h0, 5'd1, 5'd2);
        step();
        drive(6'h00, 6'h22, 32'h66, 32'h1, 16'h0, 5'd1, 5'd2);
        step();
        in_valid = 1'b0;
        chk("ar_pre_alu", alu_ctrl, 4'b0011);
        #1 reset = 1'b1;
        #1;
        chk("ar_out_valid", out_valid, 1'b0);
        chk("ar_alu_ctrl", alu_ctrl, 4'b0000);
        chk("ar_in_ready", in_ready, 1'b1);
        chk("ar_op1", operand1, 32'h0);
        step();
        #2 reset = 1'b0;
        step();
        out_ready = 1'b1;
        issue1(6'h00, 6'h24, 32'h77, 32'h3, 16'h0, 5'd1, 5'd6);
        chk("ar_recover_alu", alu_ctrl, 4'b0010);
        step();
        chk("final_sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
